spi_slv16: RTL and testbench
============================

# spi_slv16

16-bit SPI responder that serves the opposite end of the team's 16-bit SPI master link. It stands in for the inertial sensor and A/D devices in system-level benches, and is the synthesizable slave for board-to-board links. The block does three things:
- oversamples SCLK, SS_n and MOSI on the system clock;
- shifts a parallel-loaded response word out on MISO;
- captures the incoming command word and presents it with a one-cycle ready strobe.

## Interface
Parameters: none (frame width fixed by package constant).
- clk  input  1  system clock; edge-detection logic requires clk ≥ 8× SCLK frequency
- rst  input  1  asynchronous, active-high reset
- SS_n  input  1  active-low slave select from master (asynchronous to clk)
- SCLK  input  1  serial clock, idles high (asynchronous to clk)
- MOSI  input  1  master-out data; changes on SCLK fall
- MISO  output  1  slave-out data; changes on SCLK fall; 1'bz when deselected
- tx_data  input  16  response word, sampled only at frame start
- rx_data  output  16  last complete received word
- rx_rdy  output  1  one-clk pulse when rx_data updates
- busy  output  1  high while a frame is in progress

## Operation
- Synchronization:
  - SS_n, SCLK and MOSI each pass through 2 flops, plus a third history flop for SS_n and SCLK.
  - Sync flops for SS_n and SCLK reset to 1.
  - Edge strobes are combinational from stage 2 vs stage 3: ss_fall, ss_rise, sclk_rise, sclk_fall.
- States: IDLE, ACTIVE.
- IDLE:
  - On ss_fall: tx_shft ← tx_data, bit_cnt ← 0, busy ← 1, go to ACTIVE.
  - All SCLK edges are ignored.
- ACTIVE:
  - sclk_rise: rx_shft ← {rx_shft[14:0], MOSI_sync}; bit_cnt increments, saturating at 17.
  - sclk_fall with 1 ≤ bit_cnt ≤ 15: tx_shft ← tx_shft << 1.
  - The fall preceding the first rise is the front-porch dummy fall and does not shift.
  - ss_rise with bit_cnt == 16: rx_data ← rx_shft, rx_rdy pulses, busy ← 0, go to IDLE.
  - ss_rise with any other bit_cnt: frame discarded, rx_data unchanged, no rx_rdy, busy ← 0, go to IDLE.
- MISO = tx_shft[15] while the synchronized SS_n is low; 1'bz otherwise.
- bit_cnt is 5 bits. More than 16 rises saturates it at 17, which marks the frame invalid.
- Reset values:
  - state IDLE, busy 0, rx_rdy 0, rx_data 16'h0000, bit_cnt 0, tx_shft 0, rx_shft 0.
  - MISO z (the synchronized SS_n resets high).
- Reset asserted mid-frame: all of the above are restored. If SS_n is still low after reset, no frame starts until the next SS_n falling edge.
- tx_data changes after frame start have no effect until the next frame.

## Timing
- Pin-to-action latency is 3 clk edges: capture, sync, registered action.
  - MISO updates on the 3rd clk edge after an SCLK fall.
  - tx_shft loads on the 3rd edge after an SS_n fall.
- rx_rdy goes high on the 3rd clk edge after the SS_n rise and stays high for exactly 1 cycle.
- Master half-period is 16 clk. MISO settles 13 clk before the master's sampling rise; minimum supported half-period is 4 clk.
- busy rises 3 edges after an SS_n fall and falls 3 edges after an SS_n rise.
- ss_fall and ss_rise never occur in the same cycle.
- An SCLK edge coincident with ss_rise is ignored; ss_rise has priority.

## Configuration
- SPI_SLV_FRM_ERR_EN defined:
  - Adds output frm_err (1 bit, reset 0).
  - frm_err pulses for one clk, in the cycle rx_rdy would have pulsed, whenever a frame is discarded (bit_cnt ≠ 16 at ss_rise).
- SPI_SLV_FRM_ERR_EN undefined: the port and its logic are absent; discarded frames are silent.

## Structure
- Package spi_pkg holds:
  - SPI_FRAME_BITS = 16
  - the spi_slv_state_t enum {IDLE, ACTIVE}
  - BIT_CNT_SAT = 17
- Sub-module spi_slv_sync: the 3-flop synchronizer/edge detector. It is instantiated twice (SS_n, SCLK), each instance with a reset-value parameter of 1. MOSI uses a plain 2-flop sync.
- The top holds the FSM, the counter and both shift registers.

## Test plan
- Normal frame:
  - Stimulus: master (50 MHz, SCLK = clk/32) sends cmd 16'h1234; tx_data = 16'hA5C3.
  - Required: rx_data = 16'h1234, rx_rdy exactly one pulse, master rd_data = 16'hA5C3.
- Back-to-back frames:
  - Stimulus: cmd 16'hFFFF then 16'h0001; tx_data 16'h8000 then 16'h7FFF, tx_data changed mid-frame.
  - Required: two rx_rdy pulses, rx_data 16'hFFFF then 16'h0001, master receives 16'h8000 then 16'h7FFF.
- Aborted frame:
  - Stimulus: SS_n raised after 8 SCLK rises.
  - Required: rx_data unchanged, no rx_rdy, busy returns 0; frm_err pulses once with SPI_SLV_FRM_ERR_EN.
- Reset mid-frame:
  - Stimulus: rst asserted after bit 5 while SS_n stays low, then master completes the frame.
  - Required: no rx_rdy. The next full frame with cmd 16'hBEEF yields rx_data 16'hBEEF.
- Idle bus:
  - Stimulus: SCLK toggles with SS_n high.
  - Required: MISO = z, busy = 0, no rx_rdy, rx_data = 16'h0000 after reset.
- Over-length frame:
  - Stimulus: 17 SCLK rises within one SS_n low.
  - Required: frame discarded, rx_data unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state type for the 16-bit SPI responder.
package spi_pkg;
   localparam int         SPI_FRAME_BITS = 16;
   localparam logic [4:0] BIT_CNT_SAT    = 5'd17;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_slv_state_t;
endpackage

// File: rtl/spi_slv_sync.sv
// Three-flop synchronizer for one asynchronous pin.
// Provides the synchronized level and rise/fall strobes (stage 2 vs stage 3).
module spi_slv_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);
   logic [2:0] sh_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sh_q <= {3{RST_VAL}};
      else     sh_q <= {sh_q[1:0], d_i};
   end

   assign sync_o = sh_q[1];
   assign rise_o = sh_q[1] & ~sh_q[2];
   assign fall_o = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/spi_slv16.sv
// 16-bit SPI responder: oversampled SS_n/SCLK/MOSI, parallel-loaded MISO word,
// captured command with rx_rdy strobe. Optional frm_err output: SPI_SLV_FRM_ERR_EN.
module spi_slv16
   import spi_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      SS_n,
   input  logic                      SCLK,
   input  logic                      MOSI,
   output logic                      MISO,
   input  logic [SPI_FRAME_BITS-1:0] tx_data,
   output logic [SPI_FRAME_BITS-1:0] rx_data,
   output logic                      rx_rdy,
   output logic                      busy
`ifdef SPI_SLV_FRM_ERR_EN
   ,
   output logic                      frm_err
`endif
);
   logic ss_sync, ss_rise, ss_fall;
   logic sclk_lvl_unused, sclk_rise, sclk_fall;

   spi_slv_sync #(.RST_VAL(1'b1)) u_ss_sync (
      .clk(clk), .rst(rst), .d_i(SS_n),
      .sync_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall)
   );

   spi_slv_sync #(.RST_VAL(1'b1)) u_sclk_sync (
      .clk(clk), .rst(rst), .d_i(SCLK),
      .sync_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   logic [1:0]                mosi_q;
   spi_slv_state_t            state_q;
   logic [4:0]                bit_cnt_q, bit_cnt_d;
   logic [SPI_FRAME_BITS-1:0] tx_shft_q, rx_shft_q, rx_data_q;
   logic                      rx_rdy_q, busy_q, arm_q;
   logic [1:0]                settle_q;
`ifdef SPI_SLV_FRM_ERR_EN
   logic                      frm_err_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mosi_q <= 2'b00;
      else     mosi_q <= {mosi_q[0], MOSI};
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      if (bit_cnt_q != BIT_CNT_SAT) bit_cnt_d = bit_cnt_q + 5'd1;
   end

   // The synchronizer resets high, so a pin held low through reset would look
   // like a fresh SS_n fall; frames are only accepted once SS_n has been seen high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= 5'd0;
         tx_shft_q <= '0;
         rx_shft_q <= '0;
         rx_data_q <= '0;
         rx_rdy_q  <= 1'b0;
         busy_q    <= 1'b0;
         arm_q     <= 1'b0;
         settle_q  <= 2'd0;
`ifdef SPI_SLV_FRM_ERR_EN
         frm_err_q <= 1'b0;
`endif
      end else begin
         rx_rdy_q <= 1'b0;
`ifdef SPI_SLV_FRM_ERR_EN
         frm_err_q <= 1'b0;
`endif
         if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
         else if (ss_sync)     arm_q    <= 1'b1;

         case (state_q)
            IDLE: begin
               if (ss_fall && arm_q) begin
                  tx_shft_q <= tx_data;
                  bit_cnt_q <= 5'd0;
                  busy_q    <= 1'b1;
                  state_q   <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (ss_rise) begin
                  if (bit_cnt_q == 5'(SPI_FRAME_BITS)) begin
                     rx_data_q <= rx_shft_q;
                     rx_rdy_q  <= 1'b1;
                  end
`ifdef SPI_SLV_FRM_ERR_EN
                  else begin
                     frm_err_q <= 1'b1;
                  end
`endif
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (sclk_rise) begin
                  rx_shft_q <= {rx_shft_q[SPI_FRAME_BITS-2:0], mosi_q[1]};
                  bit_cnt_q <= bit_cnt_d;
               end else if (sclk_fall && (bit_cnt_q != 5'd0) &&
                            (bit_cnt_q < 5'(SPI_FRAME_BITS))) begin
                  tx_shft_q <= tx_shft_q << 1;
               end
            end
         endcase
      end
   end

   assign MISO    = ss_sync ? 1'bz : tx_shft_q[SPI_FRAME_BITS-1];
   assign rx_data = rx_data_q;
   assign rx_rdy  = rx_rdy_q;
   assign busy    = busy_q;
`ifdef SPI_SLV_FRM_ERR_EN
   assign frm_err = frm_err_q;
`endif
endmodule

// File: tb/tb_spi_slv16.sv
// Bench for spi_slv16: table of master frames plus reset/idle sequences,
// with an rx_data scoreboard fed at each SS_n rise.
module tb_spi_slv16;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        SS_n = 1'b1;
   logic        SCLK = 1'b1;
   logic        MOSI = 1'b0;
   logic [15:0] tx_data = 16'h0000;
   wire         MISO;
   logic [15:0] rx_data;
   logic        rx_rdy;
   logic        busy;
`ifdef SPI_SLV_FRM_ERR_EN
   logic        frm_err;
`endif

   pullup (MISO);

   spi_slv16 dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .tx_data(tx_data), .rx_data(rx_data), .rx_rdy(rx_rdy), .busy(busy)
`ifdef SPI_SLV_FRM_ERR_EN
      , .frm_err(frm_err)
`endif
   );

   always #10 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_q[$];
   logic [15:0] last_rx = 16'h0000;
   int          rdy_cnt = 0, exp_rdy = 0, err_cnt = 0, exp_err = 0;
   logic        rdy_prev = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_rdy) begin
         rdy_cnt++;
         chk("rx_rdy_width_mon", {31'b0, rdy_prev}, 32'd0);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_rdy_unexpected: got rx_data %0h expected no strobe", rx_data);
         end else begin
            chk("rx_data_sb", {16'b0, rx_data}, {16'b0, exp_q.pop_front()});
         end
      end
      rdy_prev = rx_rdy;
`ifdef SPI_SLV_FRM_ERR_EN
      if (frm_err) err_cnt++;
`endif
   end

   task automatic frame(input logic [15:0] cmd, input logic [15:0] tx, input int nbits,
                        input int chg_at, input logic [15:0] chg_val, input int rst_at);
      logic [15:0] rd;
      logic        valid;
      rd      = 16'h0000;
      valid   = (nbits == 16) && (rst_at < 0);
      tx_data = tx;
      @(negedge clk);
      SS_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("busy_pre", {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk("busy_start", {31'b0, busy}, 32'd1);
      repeat (13) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = (i < 16) ? cmd[15-i] : 1'b0;
         if (i == chg_at) tx_data = chg_val;
         if (i == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            last_rx = 16'h0000;
         end
         repeat (16) @(negedge clk);
         if (i < 16) rd[15-i] = MISO;
         SCLK = 1'b1;
         repeat (16) @(negedge clk);
      end
      SS_n = 1'b1;
      if (valid) begin
         exp_q.push_back(cmd);
         last_rx = cmd;
         exp_rdy++;
      end else if (rst_at < 0) begin
         exp_err++;
      end
      repeat (2) @(negedge clk);
      chk("rx_rdy_early", {31'b0, rx_rdy}, 32'd0);
      chk("busy_hold", {31'b0, busy}, {31'b0, rst_at < 0});
      @(negedge clk);
      chk("rx_rdy_lat", {31'b0, rx_rdy}, {31'b0, valid});
      chk("busy_end", {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk("rx_rdy_one", {31'b0, rx_rdy}, 32'd0);
      chk("rx_data_hold", {16'b0, rx_data}, {16'b0, last_rx});
      if (valid) chk("master_rd", {16'b0, rd}, {16'b0, tx});
      repeat (16) @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] cmd;
      logic [15:0] tx;
      int          nbits;
      int          chg_at;
      logic [15:0] chg_val;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{16'h1234, 16'hA5C3, 16, -1, 16'h0000};
      vecs[1] = '{16'hFFFF, 16'h8000, 16,  8, 16'h7FFF};
      vecs[2] = '{16'h0001, 16'h7FFF, 16, -1, 16'h0000};
      vecs[3] = '{16'h5A5A, 16'h1111,  8, -1, 16'h0000};
      vecs[4] = '{16'h0F0F, 16'h2222, 17, -1, 16'h0000};

      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_rx_data", {16'b0, rx_data}, 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // idle bus: SCLK activity with SS_n high must be ignored
      for (int k = 0; k < 8; k++) begin
         SCLK = ~SCLK;
         repeat (4) @(negedge clk);
         chk("idle_miso_z", {31'b0, MISO}, 32'd1);
         chk("idle_busy", {31'b0, busy}, 32'd0);
      end
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
      chk("idle_rx_data", {16'b0, rx_data}, 32'd0);
      chk("idle_rx_rdy_cnt", rdy_cnt, 0);

      for (int v = 0; v < 5; v++)
         frame(vecs[v].cmd, vecs[v].tx, vecs[v].nbits, vecs[v].chg_at, vecs[v].chg_val, -1);

      // reset after bit 5 while SS_n stays low; remaining bits must not form a frame
      frame(16'h3333, 16'h4444, 16, -1, 16'h0000, 5);
      chk("post_rst_busy", {31'b0, busy}, 32'd0);
      frame(16'hBEEF, 16'hC0DE, 16, -1, 16'h0000, -1);
      chk("final_rx_data", {16'b0, rx_data}, 32'h0000BEEF);

      chk("rx_rdy_count", rdy_cnt, exp_rdy);
      chk("scoreboard_empty", exp_q.size(), 0);
`ifdef SPI_SLV_FRM_ERR_EN
      chk("frm_err_count", err_cnt, exp_err);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
